// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: SCAN elevator controller with latched requests, timed travel and door dwell
module elevator_ctrl_n #(
   parameter int NUM_FLOORS    = 8,
   parameter int FLOOR_W       = $clog2(NUM_FLOORS),
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] req,
   output logic [FLOOR_W-1:0]    floor,
   output logic                  dir,
   output logic                  moving,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending
);
   localparam int MAX_C = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int CNT_W = MAX_C > 1 ? $clog2(MAX_C) : 1;
   localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);

   typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_t;

   state_t                state_q, state_d;
   logic [FLOOR_W-1:0]    floor_q, floor_d, next_floor;
   logic                  dir_q, dir_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic                  above, below, ahead, behind, here;

   // any outstanding request strictly above or below the car
   always_comb begin
      above = 1'b0;
      below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending_q[i] && FLOOR_W'(i) > floor_q) above = 1'b1;
         if (pending_q[i] && FLOOR_W'(i) < floor_q) below = 1'b1;
      end
   end

   assign ahead      = dir_q ? above : below;
   assign behind     = dir_q ? below : above;
   assign here       = pending_q[floor_q];
   assign next_floor = dir_q ? (floor_q == TOP ? floor_q : floor_q + 1'b1)
                             : (floor_q == '0  ? floor_q : floor_q - 1'b1);

   // next state: SCAN decisions, floor stepping, door hold and request clearing
   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q + 1'b1;
      pending_d = pending_q | req;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (here) begin
               state_d            = DOOR;
               pending_d[floor_q] = 1'b0;
            end else if (ahead || behind) begin
               state_d = MOVING;
               dir_d   = ahead ? dir_q : ~dir_q;
            end
         end
         MOVING: if (cnt_q == TRAVEL_LAST) begin
            floor_d = next_floor;
            cnt_d   = '0;
            if (pending_q[next_floor]) begin
               state_d               = DOOR;
               pending_d[next_floor] = 1'b0;
            end
         end
         DOOR: if (req[floor_q]) begin
            cnt_d              = '0;
            pending_d[floor_q] = 1'b0;
         end else if (cnt_q == DOOR_LAST) begin
            cnt_d   = '0;
            state_d = (ahead || behind) ? MOVING : IDLE;
            dir_d   = (ahead || !behind) ? dir_q : ~dir_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // state registers, cleared immediately by the active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         floor_q   <= '0;
         dir_q     <= 1'b1;
         cnt_q     <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
      end
   end

   // the car must never be asked to step past either end of the shaft
   always_ff @(posedge clk) begin
      if (rst && state_q == MOVING && cnt_q == TRAVEL_LAST)
         assert (dir_q ? floor_q != TOP : floor_q != '0);
   end

   assign floor     = floor_q;
   assign dir       = dir_q;
   assign moving    = state_q == MOVING;
   assign door_open = state_q == DOOR;
   assign pending   = pending_q;
endmodule
